ex_mem_stage_buf: RTL and testbench

//  Parametrised EX->MEM pipeline boundary. Replaces the plain EX/MEM latch with a valid/ready
//  2-entry skid buffer, so MEM can backpressure EX without combinational ready paths.

---
 rtl/ex_mem_stage_buf_pkg.sv | 17 +
 rtl/ex_mem_stage_buf_if.sv | 41 ++++
 rtl/ex_mem_stage_buf_entry_reg.sv | 46 ++++
 rtl/ex_mem_stage_buf.sv | 143 ++++++++++++++
 tb/tb_ex_mem_stage_buf.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_stage_buf_pkg.sv
// EX->MEM boundary shared definitions.
// Control-field bit positions and skid FSM state encoding.
package ex_mem_pkg;

   localparam int CTRL_W         = 4;
   localparam int CTRL_REG_WRITE = 0;
   localparam int CTRL_MEM_WRITE = 1;
   localparam int CTRL_MEM_READ  = 2;

   // State is {main_valid, skid_valid}.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_TWO   = 2'b11
   } state_t;

endpackage

// File: rtl/ex_mem_stage_buf_if.sv
// EX->MEM boundary bus: EX-side input handshake,
// MEM-side output handshake and forwarding tap.
interface ex_mem_stage_buf_if #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int CTRL_W = ex_mem_pkg::CTRL_W
);
   logic              ex_valid;
   logic              ex_ready;
   logic [DATA_W-1:0] ex_result;
   logic [DATA_W-1:0] ex_store_data;
   logic [RD_W-1:0]   ex_rd;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              mem_valid;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [RD_W-1:0]   mem_rd;
   logic [CTRL_W-1:0] mem_ctrl;
   logic              fwd_valid;
   logic [RD_W-1:0]   fwd_rd;
   logic [DATA_W-1:0] fwd_data;

   // Environment side: EX producer and MEM consumer.
   modport master (
      output ex_valid, ex_result, ex_store_data,
      output ex_rd, ex_ctrl, mem_ready,
      input  ex_ready, mem_valid, mem_addr,
      input  mem_wdata, mem_rd, mem_ctrl,
      input  fwd_valid, fwd_rd, fwd_data
   );

   // Buffer side.
   modport slave (
      input  ex_valid, ex_result, ex_store_data,
      input  ex_rd, ex_ctrl, mem_ready,
      output ex_ready, mem_valid, mem_addr,
      output mem_wdata, mem_rd, mem_ctrl,
      output fwd_valid, fwd_rd, fwd_data
   );
endinterface

// File: rtl/ex_mem_stage_buf_entry_reg.sv
// One EX->MEM bundle register {result, store, rd, ctrl}.
// Loads when enabled, clears on synchronous reset.
module ex_mem_entry_reg #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_result,
   input  logic [DATA_W-1:0] i_store,
   input  logic [RD_W-1:0]   i_rd,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic [DATA_W-1:0] o_result,
   output logic [DATA_W-1:0] o_store,
   output logic [RD_W-1:0]   o_rd,
   output logic [CTRL_W-1:0] o_ctrl
);

   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_store;
   logic [RD_W-1:0]   r_rd;
   logic [CTRL_W-1:0] r_ctrl;

   // Capture the bundle on load; zero on reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_result <= '0;
         r_store  <= '0;
         r_rd     <= '0;
         r_ctrl   <= '0;
      end else if (i_load) begin
         r_result <= i_result;
         r_store  <= i_store;
         r_rd     <= i_rd;
         r_ctrl   <= i_ctrl;
      end
   end

   assign o_result = r_result;
   assign o_store  = r_store;
   assign o_rd     = r_rd;
   assign o_ctrl   = r_ctrl;

endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline boundary: 2-entry skid buffer with
// registered ready, synchronous flush and forwarding tap.
module ex_mem_stage_buf #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int CTRL_W = ex_mem_pkg::CTRL_W
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           flush,
   ex_mem_stage_buf_if.slave bus
);
   import ex_mem_pkg::state_t;
   import ex_mem_pkg::ST_EMPTY;
   import ex_mem_pkg::ST_ONE;
   import ex_mem_pkg::ST_TWO;
   import ex_mem_pkg::CTRL_REG_WRITE;

   state_t r_state;
   logic   r_mem_valid;
   logic   r_ex_ready;

   state_t w_nxt;
   logic   w_accept;
   logic   w_drain;
   logic   w_ld_main;
   logic   w_ld_skid;

   logic [DATA_W-1:0] w_sk_result;
   logic [DATA_W-1:0] w_sk_store;
   logic [RD_W-1:0]   w_sk_rd;
   logic [CTRL_W-1:0] w_sk_ctrl;

   logic [DATA_W-1:0] w_src_result;
   logic [DATA_W-1:0] w_src_store;
   logic [RD_W-1:0]   w_src_rd;
   logic [CTRL_W-1:0] w_src_ctrl;

   logic [DATA_W-1:0] w_mn_result;
   logic [DATA_W-1:0] w_mn_store;
   logic [RD_W-1:0]   w_mn_rd;
   logic [CTRL_W-1:0] w_mn_ctrl;

   assign w_accept = bus.ex_valid & r_ex_ready;
   assign w_drain  = r_mem_valid & bus.mem_ready;

   // Main refills from skid when draining out of TWO.
   assign w_src_result = (r_state == ST_TWO) ? w_sk_result : bus.ex_result;
   assign w_src_store  = (r_state == ST_TWO) ? w_sk_store  : bus.ex_store_data;
   assign w_src_rd     = (r_state == ST_TWO) ? w_sk_rd     : bus.ex_rd;
   assign w_src_ctrl   = (r_state == ST_TWO) ? w_sk_ctrl   : bus.ex_ctrl;

   // Next-state and entry load enables from accept/drain.
   always_comb begin
      w_nxt     = r_state;
      w_ld_main = 1'b0;
      w_ld_skid = 1'b0;
      unique case (r_state)
         ST_EMPTY: begin
            w_ld_main = w_accept;
            if (w_accept) w_nxt = ST_ONE;
         end
         ST_ONE: begin
            w_ld_main = w_accept & w_drain;
            w_ld_skid = w_accept & ~w_drain;
            if (w_accept & ~w_drain)      w_nxt = ST_TWO;
            else if (~w_accept & w_drain) w_nxt = ST_EMPTY;
         end
         ST_TWO: begin
            w_ld_main = w_drain;
            if (w_drain) w_nxt = ST_ONE;
         end
         default: w_nxt = ST_EMPTY;
      endcase
      if (flush) begin
         w_nxt     = ST_EMPTY;
         w_ld_main = 1'b0;
         w_ld_skid = 1'b0;
      end
   end

   // Control FSM with registered valid/ready outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= ST_EMPTY;
         r_mem_valid <= 1'b0;
         r_ex_ready  <= 1'b1;
      end else begin
         r_state     <= w_nxt;
         r_mem_valid <= w_nxt[1];
         r_ex_ready  <= ~w_nxt[0];
      end
   end

   ex_mem_entry_reg #(
      .DATA_W (DATA_W),
      .RD_W   (RD_W),
      .CTRL_W (CTRL_W)
   ) u_skid (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_ld_skid),
      .i_result (bus.ex_result),
      .i_store  (bus.ex_store_data),
      .i_rd     (bus.ex_rd),
      .i_ctrl   (bus.ex_ctrl),
      .o_result (w_sk_result),
      .o_store  (w_sk_store),
      .o_rd     (w_sk_rd),
      .o_ctrl   (w_sk_ctrl)
   );

   ex_mem_entry_reg #(
      .DATA_W (DATA_W),
      .RD_W   (RD_W),
      .CTRL_W (CTRL_W)
   ) u_main (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_ld_main),
      .i_result (w_src_result),
      .i_store  (w_src_store),
      .i_rd     (w_src_rd),
      .i_ctrl   (w_src_ctrl),
      .o_result (w_mn_result),
      .o_store  (w_mn_store),
      .o_rd     (w_mn_rd),
      .o_ctrl   (w_mn_ctrl)
   );

   assign bus.ex_ready  = r_ex_ready;
   assign bus.mem_valid = r_mem_valid;
   assign bus.mem_addr  = w_mn_result;
   assign bus.mem_wdata = w_mn_store;
   assign bus.mem_rd    = w_mn_rd;
   assign bus.mem_ctrl  = w_mn_ctrl;
   assign bus.fwd_rd    = w_mn_rd;
   assign bus.fwd_data  = w_mn_result;
   assign bus.fwd_valid = r_mem_valid
                        & w_mn_ctrl[CTRL_REG_WRITE]
                        & (w_mn_rd != '0);

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Bench for ex_mem_stage_buf: directed handshake cases
// plus a random valid/ready scoreboard run.
module tb_ex_mem_stage_buf;

   localparam int DW = 64;
   localparam int RW = 6;
   localparam int CW = 4;

   logic clock = 1'b0;
   logic reset;
   logic flush;

   always #5 clock = ~clock;

   ex_mem_stage_buf_if #(
      .DATA_W (DW),
      .RD_W   (RW),
      .CTRL_W (CW)
   ) bus ();

   ex_mem_stage_buf #(
      .DATA_W (DW),
      .RD_W   (RW),
      .CTRL_W (CW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   typedef struct packed {
      logic [DW-1:0] res;
      logic [DW-1:0] st;
      logic [RW-1:0] rd;
      logic [CW-1:0] ctrl;
   } ent_t;

   ent_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(logic v, logic [DW-1:0] res,
                        logic [RW-1:0] rd, logic [CW-1:0] ctrl);
      bus.ex_valid      = v;
      bus.ex_result     = res;
      bus.ex_store_data = ~res;
      bus.ex_rd         = rd;
      bus.ex_ctrl       = ctrl;
   endtask

   // Scoreboard: pop on drain, push on accept, clear on flush/reset.
   always @(negedge clock) begin : mon
      ent_t e;
      if (!reset) begin
         q.delete();
      end else begin
         chk("mem_valid", 64'(bus.mem_valid), 64'(q.size() != 0));
         chk("ex_ready", 64'(bus.ex_ready), 64'(q.size() < 2));
         if (bus.mem_valid && bus.mem_ready) begin
            if (q.size() == 0) begin
               chk("extra", 64'(bus.mem_valid), 64'd0);
            end else begin
               e = q.pop_front();
               chk("sb_addr", bus.mem_addr, e.res);
               chk("sb_wdata", bus.mem_wdata, e.st);
               chk("sb_rd", 64'(bus.mem_rd), 64'(e.rd));
               chk("sb_ctrl", 64'(bus.mem_ctrl), 64'(e.ctrl));
               chk("sb_fwdv", 64'(bus.fwd_valid),
                   64'(e.ctrl[0] && (e.rd != '0)));
               chk("sb_fwdrd", 64'(bus.fwd_rd), 64'(e.rd));
               chk("sb_fwdd", bus.fwd_data, e.res);
            end
         end
         if (flush)
            q.delete();
         else if (bus.ex_valid && bus.ex_ready)
            q.push_back({bus.ex_result, bus.ex_store_data,
                         bus.ex_rd, bus.ex_ctrl});
      end
   end

   initial begin
      reset         = 1'b0;
      flush         = 1'b0;
      bus.mem_ready = 1'b0;
      drive(1'b1, 64'h99, 6'd3, 4'h1);

      // Reset held with ex_valid high.
      cyc();
      cyc();
      chk("rst_mvalid", 64'(bus.mem_valid), 64'd0);
      chk("rst_addr", bus.mem_addr, 64'd0);
      chk("rst_ready", 64'(bus.ex_ready), 64'd1);
      chk("rst_fwdv", 64'(bus.fwd_valid), 64'd0);
      reset = 1'b1;
      drive(1'b0, 64'h0, 6'd0, 4'h0);
      cyc();

      // Streaming with MEM always ready.
      bus.mem_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 64'(i * 16), 6'(i), 4'h1);
         cyc();
         chk("str_ready", 64'(bus.ex_ready), 64'd1);
         chk("str_addr", bus.mem_addr, 64'(i * 16));
         chk("str_rd", 64'(bus.mem_rd), 64'(i));
      end
      drive(1'b0, 64'h0, 6'd0, 4'h0);
      cyc();
      chk("str_empty", 64'(bus.mem_valid), 64'd0);

      // Backpressure fills skid; 0xC offered while not ready.
      bus.mem_ready = 1'b0;
      drive(1'b1, 64'hA, 6'd10, 4'h1);
      cyc();
      chk("bp_addrA", bus.mem_addr, 64'hA);
      chk("bp_ready1", 64'(bus.ex_ready), 64'd1);
      drive(1'b1, 64'hB, 6'd11, 4'h1);
      cyc();
      chk("bp_ready0", 64'(bus.ex_ready), 64'd0);
      chk("bp_holdA", bus.mem_addr, 64'hA);
      drive(1'b1, 64'hC, 6'd12, 4'h1);
      cyc();
      chk("bp_holdA2", bus.mem_addr, 64'hA);
      chk("bp_wdataA", bus.mem_wdata, ~64'hA);
      bus.mem_ready = 1'b1;
      drive(1'b0, 64'h0, 6'd0, 4'h0);
      cyc();
      chk("bp_addrB", bus.mem_addr, 64'hB);
      chk("bp_ready2", 64'(bus.ex_ready), 64'd1);
      cyc();
      chk("bp_empty", 64'(bus.mem_valid), 64'd0);

      // Flush while in TWO with a new entry offered.
      bus.mem_ready = 1'b0;
      drive(1'b1, 64'h100, 6'd1, 4'h1);
      cyc();
      drive(1'b1, 64'h200, 6'd2, 4'h1);
      cyc();
      flush = 1'b1;
      drive(1'b1, 64'h300, 6'd3, 4'h1);
      cyc();
      flush = 1'b0;
      drive(1'b0, 64'h0, 6'd0, 4'h0);
      chk("fl_mvalid", 64'(bus.mem_valid), 64'd0);
      chk("fl_ready", 64'(bus.ex_ready), 64'd1);
      chk("fl_fwdv", 64'(bus.fwd_valid), 64'd0);
      bus.mem_ready = 1'b1;
      cyc();
      cyc();
      chk("fl_none", 64'(bus.mem_valid), 64'd0);

      // Forwarding tap.
      bus.mem_ready = 1'b0;
      drive(1'b1, 64'hDEAD, 6'd5, 4'b0001);
      cyc();
      drive(1'b0, 64'h0, 6'd0, 4'h0);
      chk("fw_valid", 64'(bus.fwd_valid), 64'd1);
      chk("fw_rd", 64'(bus.fwd_rd), 64'd5);
      chk("fw_data", bus.fwd_data, 64'hDEAD);
      bus.mem_ready = 1'b1;
      cyc();
      drive(1'b1, 64'h1234, 6'd0, 4'b0001);
      cyc();
      chk("fw_rd0_mv", 64'(bus.mem_valid), 64'd1);
      chk("fw_rd0", 64'(bus.fwd_valid), 64'd0);
      drive(1'b1, 64'h5678, 6'd7, 4'b0110);
      cyc();
      chk("fw_nowr_mv", 64'(bus.mem_valid), 64'd1);
      chk("fw_nowr", 64'(bus.fwd_valid), 64'd0);
      drive(1'b0, 64'h0, 6'd0, 4'h0);
      cyc();

      // Reset in TWO wins over the offered transfer.
      bus.mem_ready = 1'b0;
      drive(1'b1, 64'h11, 6'd9, 4'hF);
      cyc();
      drive(1'b1, 64'h22, 6'd9, 4'hF);
      cyc();
      reset = 1'b0;
      drive(1'b1, 64'h33, 6'd9, 4'hF);
      cyc();
      chk("mr_mvalid", 64'(bus.mem_valid), 64'd0);
      chk("mr_addr", bus.mem_addr, 64'd0);
      chk("mr_wdata", bus.mem_wdata, 64'd0);
      chk("mr_rd", 64'(bus.mem_rd), 64'd0);
      chk("mr_ctrl", 64'(bus.mem_ctrl), 64'd0);
      chk("mr_ready", 64'(bus.ex_ready), 64'd1);
      chk("mr_fwdv", 64'(bus.fwd_valid), 64'd0);
      reset = 1'b1;
      drive(1'b0, 64'h0, 6'd0, 4'h0);
      cyc();

      // Random valid/ready traffic with occasional flush.
      for (int i = 0; i < 1500; i++) begin
         drive(1'($urandom_range(0, 1)),
               {$urandom, $urandom},
               6'($urandom_range(0, 63)),
               4'($urandom_range(0, 15)));
         bus.mem_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 63) == 0);
         cyc();
      end
      flush = 1'b0;
      drive(1'b0, 64'h0, 6'd0, 4'h0);
      bus.mem_ready = 1'b1;
      repeat (4) cyc();
      chk("drained", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
